// File: rtl/control_acceso_param_pkg.sv
// Shared types and constants for the parking-gate access controller and its benches.
package control_acceso_pkg;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    ESPERA_PIN = 3'd1,
    ABIERTO    = 3'd2,
    ALARMA     = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

  localparam logic [7:0] PIN_CORRECTO_DEF = 8'b0000_1000;
  localparam logic [7:0] PIN_ESPERA       = 8'b0000_0000;

endpackage

// File: rtl/control_acceso_param_if.sv
// Sensor, PIN-entry and gate-output bundle; master drives the sensors, slave is the controller.
interface control_acceso_param_if #(
  parameter int PIN_WIDTH    = 8,
  parameter int MAX_INTENTOS = 3
);
  localparam int IW = $clog2(MAX_INTENTOS + 1);

  logic                 Vehiculo;
  logic                 Termino;
  logic [PIN_WIDTH-1:0] Pin;
  logic                 Pin_valido;
  logic                 Cerrado;
  logic                 Abierto;
  logic                 Alarma;
  logic                 Bloqueo;
  logic [IW-1:0]        Intentos;

  modport master (
    output Vehiculo, Termino, Pin, Pin_valido,
    input  Cerrado, Abierto, Alarma, Bloqueo, Intentos
  );

  modport slave (
    input  Vehiculo, Termino, Pin, Pin_valido,
    output Cerrado, Abierto, Alarma, Bloqueo, Intentos
  );
endinterface

// File: rtl/control_acceso_param_temporizador_pin.sv
// PIN-entry timeout counter: pulses expiry on the cycle the count sits at TIMEOUT_CICLOS-1.
module temporizador_pin #(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expiry
);
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] cuenta;

  assign expiry = enable && (cuenta == ULTIMO);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cuenta <= '0;
    end else if (!enable || clear || expiry) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/control_acceso_param.sv
// Parking-gate access controller: Moore FSM with wrong-attempt counter, PIN timeout and tailgating lockout.
module control_acceso_param
  import control_acceso_pkg::*;
#(
  parameter int                   PIN_WIDTH      = 8,
  parameter logic [PIN_WIDTH-1:0] PIN_CORRECTO   = PIN_WIDTH'(PIN_CORRECTO_DEF),
  parameter int                   MAX_INTENTOS   = 3,
  parameter int                   TIMEOUT_CICLOS = 16
) (
  input logic                    Clk,
  input logic                    Reset,
  control_acceso_param_if.slave  bus
);
  localparam int IW = $clog2(MAX_INTENTOS + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INTENTOS);

  estado_t       estado_q, estado_d;
  logic [IW-1:0] intentos_q, intentos_d;
  logic [IW-1:0] intentos_inc;
  logic          pin_ok;
  logic          timer_clear;
  logic          timer_en;
  logic          expiry;
  logic          fallo;

  assign pin_ok       = bus.Pin_valido && (bus.Pin == PIN_CORRECTO);
  assign intentos_inc = (intentos_q == MAX_CNT) ? intentos_q : intentos_q + 1'b1;
  assign timer_en     = (estado_q == ESPERA_PIN);
  assign timer_clear  = timer_en && bus.Pin_valido;

  temporizador_pin #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_temporizador (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expiry (expiry)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado_q   <= ESPERA;
      intentos_q <= '0;
    end else begin
      estado_q   <= estado_d;
      intentos_q <= intentos_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    estado_d   = estado_q;
    intentos_d = intentos_q;
    fallo      = 1'b0;

    case (estado_q)
      ESPERA: begin
        if (bus.Vehiculo) estado_d = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        // A strobe beats both the timeout and the vehicle leaving in the same cycle.
        if (bus.Pin_valido) begin
          if (pin_ok) begin
            estado_d   = ABIERTO;
            intentos_d = '0;
          end else begin
            fallo = 1'b1;
          end
        end else if (!bus.Vehiculo) begin
          estado_d = ESPERA;
        end else if (expiry) begin
          fallo = 1'b1;
        end
        if (fallo) begin
          intentos_d = intentos_inc;
          if (intentos_inc == MAX_CNT) estado_d = ALARMA;
        end
      end
      ALARMA: begin
        if (pin_ok) begin
          estado_d   = ABIERTO;
          intentos_d = '0;
        end
      end
      ABIERTO: begin
        if (bus.Termino) estado_d = bus.Vehiculo ? BLOQUEO : ESPERA;
      end
      BLOQUEO: begin
        if (pin_ok) begin
          estado_d   = ESPERA;
          intentos_d = '0;
        end
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  assign bus.Abierto  = (estado_q == ABIERTO);
  assign bus.Cerrado  = !bus.Abierto;
  assign bus.Alarma   = (estado_q == ALARMA);
  assign bus.Bloqueo  = (estado_q == BLOQUEO);
  assign bus.Intentos = intentos_q;

endmodule

// File: tb/tb_control_acceso_param.sv
// Bench for control_acceso_param: table-driven vectors plus multi-cycle sequences, checked via a scoreboard queue.
module tb_control_acceso_param;
  import control_acceso_pkg::*;

  // Expected outputs packed as {Cerrado, Abierto, Alarma, Bloqueo, Intentos[1:0]}.
  typedef struct {
    logic [5:0] esperado;
    string      nombre;
  } exp_t;

  typedef struct {
    logic       veh;
    logic       ter;
    logic [7:0] pin;
    logic       pv;
    logic [5:0] esperado;
    string      nombre;
  } vec_t;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  control_acceso_param_if #(.PIN_WIDTH(8), .MAX_INTENTOS(3)) bus ();

  control_acceso_param #(
    .PIN_WIDTH      (8),
    .PIN_CORRECTO   (PIN_CORRECTO_DEF),
    .MAX_INTENTOS   (3),
    .TIMEOUT_CICLOS (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock starts high: negedges at 5, 15, ... and posedges at 10, 20, ...
  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [5:0] salidas();
    return {bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo, bus.Intentos};
  endfunction

  task automatic check(input string nombre, input logic [5:0] act, input logic [5:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s: got cer=%b ab=%b al=%b bl=%b int=%0d, want cer=%b ab=%b al=%b bl=%b int=%0d",
               nombre, act[5], act[4], act[3], act[2], act[1:0],
               esp[5], esp[4], esp[3], esp[2], esp[1:0]);
    end
  endtask

  // Scoreboard: compare one queued expectation shortly after each rising edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.nombre, salidas(), e.esperado);
    end
  end

  task automatic drive(input logic veh, input logic ter, input logic [7:0] pin, input logic pv);
    @(negedge Clk);
    bus.Vehiculo   = veh;
    bus.Termino    = ter;
    bus.Pin        = pin;
    bus.Pin_valido = pv;
  endtask

  task automatic step(input logic veh, input logic ter, input logic [7:0] pin, input logic pv,
                      input logic [5:0] esperado, input string nombre);
    exp_t e;
    drive(veh, ter, pin, pv);
    e.esperado = esperado;
    e.nombre   = nombre;
    exp_q.push_back(e);
  endtask

  task automatic idle_veh(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, PIN_ESPERA, 1'b0);
  endtask

  vec_t tabla[15];

  initial begin
    checks = 0;
    errors = 0;
    bus.Vehiculo   = 1'b0;
    bus.Termino    = 1'b0;
    bus.Pin        = PIN_ESPERA;
    bus.Pin_valido = 1'b0;
    Reset          = 1'b0;

    tabla[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'b100000, "llega_vehiculo"};
    tabla[1]  = '{1'b1, 1'b0, 8'h08, 1'b1, 6'b010000, "pin_correcto_abre"};
    tabla[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 6'b100000, "termino_cierra"};
    tabla[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'b100000, "llega_otro"};
    tabla[4]  = '{1'b1, 1'b0, 8'h09, 1'b1, 6'b100001, "pin_un_bit_mal"};
    tabla[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 6'b100010, "pin_ceros"};
    tabla[6]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 6'b101011, "tercer_fallo_alarma"};
    tabla[7]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 6'b101011, "alarma_satura"};
    tabla[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 6'b101011, "alarma_sin_vehiculo"};
    tabla[9]  = '{1'b1, 1'b0, 8'h08, 1'b1, 6'b010000, "alarma_pin_correcto"};
    tabla[10] = '{1'b0, 1'b0, 8'h08, 1'b1, 6'b010000, "abierto_ignora_pin"};
    tabla[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 6'b100100, "colado_bloqueo"};
    tabla[12] = '{1'b0, 1'b0, 8'hFF, 1'b1, 6'b100100, "bloqueo_ignora_mal"};
    tabla[13] = '{1'b0, 1'b0, 8'h08, 1'b1, 6'b100000, "bloqueo_pin_correcto"};
    tabla[14] = '{1'b0, 1'b0, 8'h08, 1'b1, 6'b100000, "espera_ignora_pin"};

    // Reset pulse 5 -> 15 ns, released between edges.
    #5 Reset = 1'b1;
    #3 check("reset_estado", salidas(), 6'b100000);
    #7 Reset = 1'b0;

    foreach (tabla[i])
      step(tabla[i].veh, tabla[i].ter, tabla[i].pin, tabla[i].pv, tabla[i].esperado, tabla[i].nombre);

    // Timeout: entry edge E0, then expiries at E16, E32, E48.
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100000, "timeout_entrada");
    idle_veh(14);
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100000, "timeout_aun_no");
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100001, "timeout_1");
    idle_veh(15);
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100010, "timeout_2");
    idle_veh(15);
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b101011, "timeout_3_alarma");
    idle_veh(20);
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b101011, "alarma_sin_timeout");
    step(1'b1, 1'b0, 8'h08, 1'b1, 6'b010000, "timeout_sale_alarma");
    step(1'b0, 1'b1, PIN_ESPERA, 1'b0, 6'b100000, "timeout_cierra");

    // Attempts survive vehicle departure; strobe beats Vehiculo=0.
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100000, "salida_entra");
    step(1'b1, 1'b0, 8'hFF, 1'b1, 6'b100001, "salida_un_fallo");
    step(1'b0, 1'b0, PIN_ESPERA, 1'b0, 6'b100001, "salida_retiene");
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100001, "salida_vuelve");
    step(1'b0, 1'b0, 8'h08, 1'b1, 6'b010000, "strobe_prioridad");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
    end

    // Asynchronous reset mid-cycle while the gate is open.
    @(negedge Clk);
    check("pre_reset_abierto", salidas(), 6'b010000);
    #2 Reset = 1'b1;
    #1 check("reset_asincrono", salidas(), 6'b100000);
    @(negedge Clk);
    Reset = 1'b0;
    step(1'b1, 1'b0, PIN_ESPERA, 1'b0, 6'b100000, "post_reset_espera_pin");
    step(1'b1, 1'b0, 8'hFF, 1'b1, 6'b100001, "post_reset_cuenta");
    @(posedge Clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_acceso_param.md
Name: control_acceso_param

Overview:
- Parametrised parking-gate access controller. It is the next-generation DUT driven by the team's `probador` benches.
- It takes vehicle-arrival (`Vehiculo`) and passage-complete (`Termino`) sensors plus a strobed PIN entry, and drives the gate outputs `Cerrado`, `Abierto`, `Alarma` and `Bloqueo`.
- New over the previous generation: configurable PIN width and value, a wrong-attempt limit, a PIN-entry timeout, a tailgating block, and an explicit `Pin_valido` strobe.

Parameters:
- PIN_WIDTH, 8, width of the `Pin` bus.
- PIN_CORRECTO, 8'b00001000, the accepted PIN (PIN_WIDTH bits).
- MAX_INTENTOS, 3, consecutive wrong attempts that raise `Alarma`; must be ≥1.
- TIMEOUT_CICLOS, 16, cycles allowed in PIN entry without a `Pin_valido`; must be ≥2.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Vehiculo  input  1  vehicle-present sensor at the gate.
- Termino  input  1  vehicle-passed sensor behind the gate.
- Pin  input  PIN_WIDTH  entered PIN; sampled only when `Pin_valido`=1.
- Pin_valido  input  1  one-cycle strobe marking a PIN submission.
- Cerrado  output  1  gate closed.
- Abierto  output  1  gate open.
- Alarma  output  1  wrong-PIN alarm.
- Bloqueo  output  1  tailgating lockout.
- Intentos  output  $clog2(MAX_INTENTOS+1)  current wrong-attempt count.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state: ESPERA, Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, Intentos=0, timer=0.
- Reset asserted mid-operation returns to these values immediately, without waiting for a clock edge.
- Moore machine: all outputs decode from the registered state and Intentos register.
  - Latency: an input sampled at edge N is visible on the outputs right after edge N.
- States:
  - ESPERA
  - ESPERA_PIN
  - ABIERTO
  - ALARMA
  - BLOQUEO
- Output decode: Abierto=1 only in ABIERTO; Cerrado=!Abierto; Alarma=1 only in ALARMA; Bloqueo=1 only in BLOQUEO.
- ESPERA:
  - Vehiculo=1 -> ESPERA_PIN, timer cleared.
  - `Pin_valido` is ignored in this state.
- ESPERA_PIN:
  - Pin_valido=1 and Pin==PIN_CORRECTO -> ABIERTO; Intentos cleared to 0.
  - Pin_valido=1 and Pin!=PIN_CORRECTO -> Intentos+1; timer cleared.
    - If the new count equals MAX_INTENTOS -> ALARMA.
    - Otherwise stay in ESPERA_PIN.
  - No strobe and timer reaches TIMEOUT_CICLOS-1 -> counts as one wrong attempt, with the same rules as a wrong PIN; timer restarts.
  - Vehiculo=0 with no strobe that cycle -> ESPERA.
    - Intentos is retained across vehicle departure (anti brute-force).
  - A strobe takes priority over the timeout and over Vehiculo=0 in the same cycle.
- ALARMA:
  - Intentos holds at MAX_INTENTOS (saturates); wrong PINs and the timeout have no effect.
  - A correct PIN -> ABIERTO, Intentos=0.
- ABIERTO:
  - Termino=1 and Vehiculo=0 -> ESPERA.
  - Termino=1 and Vehiculo=1 in the same cycle (second vehicle tailgating) -> BLOQUEO.
  - Termino=0 -> stay in ABIERTO, with no timeout; `Pin_valido` is ignored.
- BLOQUEO:
  - Only a correct PIN exits -> ESPERA, Intentos=0.
  - Wrong PINs are ignored and do not count.
- Width rules:
  - Timer width is $clog2(TIMEOUT_CICLOS); the timer runs only in ESPERA_PIN and is held at 0 elsewhere.
  - Intentos never wraps; it saturates at MAX_INTENTOS.
  - The PIN compare is full-width equality.
- Unknown or illegal state encoding -> ESPERA on the next edge.

Decomposition:
- Shared package `control_acceso_pkg` holds:
  - the state enum (ESPERA, ESPERA_PIN, ABIERTO, ALARMA, BLOQUEO), 3-bit encoding;
  - the default PIN_CORRECTO and PIN_ESPERA (all zeros) constants, shared with the benches.
- One sub-module is natural: `temporizador_pin`, the timeout counter.
  - Inputs: clear, enable.
  - Output: expiry pulse.
  - Parameter: TIMEOUT_CICLOS.
- The FSM, attempt counter and output decode stay in the top module.

Test Plan:
- Reset pulse 5→15 ns, then Vehiculo=1, Pin=8'h08 with Pin_valido for 1 cycle -> Abierto=1, Cerrado=0 the edge after the strobe; Intentos=0.
- Vehiculo=1, three strobes of Pin=8'hFF -> Intentos 1, 2, 3; Alarma=1 after the third; then Pin=8'h08 strobe -> Alarma=0, Abierto=1, Intentos=0.
- In ABIERTO, Termino=1 with Vehiculo=1 in the same cycle -> Bloqueo=1, Cerrado=1; Pin=8'hFF strobe -> no change; Pin=8'h08 strobe -> Bloqueo=0, state ESPERA.
- Vehiculo=1 held, no strobe for 16 cycles -> Intentos=1; after 48 cycles total -> Alarma=1, Intentos=3 thereafter.
- One wrong PIN (Intentos=1), Vehiculo drops -> ESPERA, Intentos still 1; Vehiculo returns, Pin_valido with Pin=8'h08 and Vehiculo=0 in the same cycle -> ABIERTO (strobe priority).
- Reset asserted between clock edges while in ABIERTO -> immediately Cerrado=1, Abierto=0, Intentos=0.
